// File: rtl/unified_mem_arbiter_pkg.sv
// unified_mem_arbiter_pkg: shared state and address-mux select encodings for the unified memory arbiter.
package unified_mem_arbiter_pkg;
    typedef enum logic {ST_IDLE = 1'b0, ST_ACCESS = 1'b1} state_t;
    typedef enum logic [1:0] {
        SEL_FETCH = 2'd0,
        SEL_DATA  = 2'd1,
        SEL_RSV2  = 2'd2,
        SEL_RSV3  = 2'd3
    } sel_t;
endpackage

// File: rtl/unified_mem_arbiter_if.sv
// unified_mem_arbiter_if: fetch/MEM request handshakes and memory control bundle.
interface unified_mem_arbiter_if;
    logic       if_req;
    logic       if_ready;
    logic       d_req;
    logic       d_we;
    logic       d_ready;
    logic [1:0] mem_sel;
    logic       mem_en;
    logic       mem_we;
    logic       busy;
    modport slave (
        input  if_req, d_req, d_we,
        output if_ready, d_ready, mem_sel, mem_en, mem_we, busy
    );
    modport master (
        output if_req, d_req, d_we,
        input  if_ready, d_ready, mem_sel, mem_en, mem_we, busy
    );
endinterface

// File: rtl/unified_mem_arbiter_access_timer.sv
// unified_mem_arbiter_access_timer: loadable down-counter with zero flag; holds at zero.
module unified_mem_arbiter_access_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);
    logic [WIDTH-1:0] count_q;
    always_ff @(posedge clk or posedge rst)
        if (rst)
            count_q <= '0;
        else if (load)
            count_q <= load_val;
        else if (dec && !zero)
            count_q <= count_q - WIDTH'(1);
    assign zero = count_q == '0;
endmodule

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares the single-ported unified memory between fetch and MEM,
// holding each grant for MEM_LATENCY cycles and bounding data streaks while fetch waits.
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int MEM_LATENCY     = 1,
    parameter int DATA_MAX_STREAK = 3
) (
    input logic                   clk,
    input logic                   rst,
    unified_mem_arbiter_if.slave  bus
);
    localparam logic [3:0] LOAD_VAL   = 4'(MEM_LATENCY - 1);
    localparam logic [3:0] MAX_STREAK = 4'(DATA_MAX_STREAK);
    state_t     state_q, state_d;
    sel_t       grant_q, grant_d;
    logic       we_q, we_d;
    logic [3:0] streak_q, streak_d;
    logic       load, zero, access, take_data;
    // Data wins collisions unless fetch has already waited out a full streak.
    assign take_data = bus.d_req && !(bus.if_req && streak_q == MAX_STREAK);
    assign access    = state_q == ST_ACCESS;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= SEL_FETCH;
            we_q     <= 1'b0;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            we_q     <= we_d;
            streak_q <= streak_d;
        end
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        we_d     = we_q;
        streak_d = streak_q;
        load     = 1'b0;
        if (state_q == ST_IDLE) begin
            if (bus.if_req || bus.d_req) begin
                load     = 1'b1;
                state_d  = ST_ACCESS;
                grant_d  = take_data ? SEL_DATA : SEL_FETCH;
                we_d     = take_data ? bus.d_we : we_q;
                streak_d = (take_data && bus.if_req) ?
                           (streak_q == MAX_STREAK ? streak_q : streak_q + 4'd1) : 4'd0;
            end
        end else if (zero)
            state_d = ST_IDLE;
    end
    unified_mem_arbiter_access_timer #(.WIDTH(4)) timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (LOAD_VAL),
        .dec      (access),
        .zero     (zero)
    );
    // Every output decodes registered state only, so no req reaches an output combinationally.
    assign bus.mem_en   = access;
    assign bus.busy     = access;
    assign bus.mem_sel  = access ? grant_q : SEL_FETCH;
    assign bus.mem_we   = access && grant_q == SEL_DATA && we_q;
    assign bus.if_ready = access && zero && grant_q == SEL_FETCH;
    assign bus.d_ready  = access && zero && grant_q == SEL_DATA;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: randomized scoreboard bench; one lane at MEM_LATENCY=2 and one at 1.
module tb_unified_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int vectors = 0;
    int miscompares = 0;
    int mode = 0;
    always #5 clk = ~clk;

    typedef struct {
        int   start_c;
        int   end_c;
        logic data;
        logic we;
    } acc_t;

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b (if_ready d_ready en we sel[1:0] busy)", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int L    = g == 0 ? 2 : 1;
        localparam int MAXS = 3;
        unified_mem_arbiter_if bus();
        unified_mem_arbiter #(.MEM_LATENCY(L), .DATA_MAX_STREAK(MAXS)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
        acc_t q[$];
        int cyc = 0;
        int free_at = 0;
        int streak = 0;

        // Requesters: hold req until ready, sometimes drop early, wiggle d_we while waiting.
        initial begin
            bus.if_req = 1'b0;
            bus.d_req  = 1'b0;
            bus.d_we   = 1'b0;
            forever begin
                @(negedge clk);
                if (mode == 2) begin
                    bus.if_req = 1'b0;
                    bus.d_req  = 1'b0;
                end else begin
                    if (bus.if_ready || !bus.if_req)
                        bus.if_req = mode == 1 || $urandom_range(0, 99) < 40;
                    else if (mode == 0 && $urandom_range(0, 99) < 3)
                        bus.if_req = 1'b0;
                    if (bus.d_ready || !bus.d_req) begin
                        bus.d_req = mode == 1 || $urandom_range(0, 99) < 50;
                        bus.d_we  = 1'($urandom_range(0, 1));
                    end else begin
                        if ($urandom_range(0, 99) < 30) bus.d_we = ~bus.d_we;
                        if (mode == 0 && $urandom_range(0, 99) < 3) bus.d_req = 1'b0;
                    end
                end
            end
        end

        // Reference model: one access at a time, L cycles long, one idle cycle after.
        initial begin
            logic take_d;
            forever begin
                @(posedge clk);
                cyc++;
                if (!rst && cyc >= free_at && (bus.if_req || bus.d_req)) begin
                    take_d = bus.d_req && !(bus.if_req && streak >= MAXS);
                    streak = (take_d && bus.if_req) ? (streak + 1 > MAXS ? MAXS : streak + 1) : 0;
                    q.push_back('{cyc, cyc + L - 1, take_d, take_d && bus.d_we});
                    free_at = cyc + L + 1;
                end
            end
        end

        // Reset aborts everything and must clear outputs without waiting for a clock.
        initial forever begin
            @(posedge rst);
            q.delete();
            streak  = 0;
            free_at = 0;
            #1;
            check($sformatf("lane%0d async_reset", g),
                  {bus.if_ready, bus.d_ready, bus.mem_en, bus.mem_we, bus.mem_sel, bus.busy}, 7'd0);
        end

        initial begin
            logic [6:0] exp;
            forever begin
                @(posedge clk);
                #3;
                exp = 7'd0;
                if (q.size() > 0 && q[0].start_c <= cyc) begin
                    exp = {q[0].end_c == cyc && !q[0].data, q[0].end_c == cyc && q[0].data,
                           1'b1, q[0].we, q[0].data ? 2'd1 : 2'd0, 1'b1};
                    if (q[0].end_c <= cyc) void'(q.pop_front());
                end
                check($sformatf("lane%0d cyc%0d", g, cyc),
                      {bus.if_ready, bus.d_ready, bus.mem_en, bus.mem_we, bus.mem_sel, bus.busy}, exp);
            end
        end
    end

    initial begin
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst  = 1'b0;
        mode = 2;
        repeat (6) @(negedge clk);
        mode = 0;
        repeat (600) @(negedge clk);
        mode = 1;
        repeat (80) @(negedge clk);
        for (int i = 0; i < 25; i++) begin
            mode = $urandom_range(0, 1);
            repeat ($urandom_range(2, 30)) @(negedge clk);
            rst = 1'b1;
            repeat ($urandom_range(1, 2)) @(negedge clk);
            rst = 1'b0;
        end
        mode = 2;
        rst  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        mode = 0;
        repeat (600) @(negedge clk);
        mode = 1;
        repeat (60) @(negedge clk);
        mode = 2;
        repeat (8) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
Sequences the single-ported unified instruction/data memory of the pipelined RV32 core, sharing it between the fetch stage and the load/store (MEM) stage.
Grants one requester at a time and drives the select of the 4-to-1 memory-address mux: 0 = PC, 1 = data address, 2/3 reserved.
Holds the access for a fixed memory latency, then pulses a one-cycle ready back to the granted stage.
Ungranted stages stall on (req & ~ready).

Parameters:
MEM_LATENCY, 1, cycles mem_en is held per access; legal range 1..15.
DATA_MAX_STREAK, 3, consecutive data grants allowed while a fetch waits before fetch is forced; legal range 1..15.

Ports:
clk  input  1  core clock, rising edge
rst  input  1  asynchronous, active-high reset
if_req  input  1  fetch stage requests an instruction read; held until if_ready
if_ready  output  1  one-cycle pulse: fetch access completes, instruction valid this cycle
d_req  input  1  MEM stage requests a load/store; held until d_ready
d_we  input  1  1 = store; sampled at grant
d_ready  output  1  one-cycle pulse: data access completes, load data valid this cycle
mem_sel  output  2  address/control mux select: 0 fetch, 1 data
mem_en  output  1  memory enable, high for the whole access
mem_we  output  1  memory write enable, high for the whole store access
busy  output  1  high while in ACCESS

Behaviour:
- Reset (async, any time): state=IDLE, counter=0, streak=0, grant=fetch.
  - All outputs 0 immediately; mem_sel=0.
  - An in-flight access is aborted; no ready is issued for it.
- States: IDLE, ACCESS. mem_en, mem_we, mem_sel and busy are driven from registered state only.
- ready outputs are decoded from registered state and counter. No combinational path from any req to any output.
- IDLE: mem_en=0, mem_we=0, mem_sel=0, busy=0. The arbitration decision is registered at the clock edge.
  - No req: stay IDLE.
  - Only one req: grant it.
  - Both reqs: grant data, unless streak==DATA_MAX_STREAK; then grant fetch.
  - On any grant: next state ACCESS, counter=MEM_LATENCY-1.
  - On a data grant, capture d_we into we_q.
- ACCESS: mem_en=1, mem_sel=grant, mem_we=(grant==data)&we_q, busy=1.
  - counter!=0: decrement.
  - counter==0: assert if_ready or d_ready (granted requester only) for this cycle; next state IDLE.
- Latency: req seen in IDLE at cycle N → ready at cycle N+MEM_LATENCY. Next grant is evaluated at N+MEM_LATENCY+1, so there is one mandatory bubble between accesses.
- Streak counter (4 bits, saturates at DATA_MAX_STREAK):
  - Increments on a data grant made while if_req=1.
  - Clears on a fetch grant.
  - Clears on a data grant made while if_req=0.
- Protocol violations:
  - req dropped mid-access: the access still completes and ready still pulses.
  - d_we changing after grant: ignored.
- if_ready and d_ready are never high together. Each is high for exactly one cycle per grant.

Decomposition:
- Shared constants header:
  - state encodings ST_IDLE/ST_ACCESS;
  - select codes SEL_FETCH=2'd0, SEL_DATA=2'd1, SEL_RSV2=2'd2, SEL_RSV3=2'd3.
  - The address mux instance uses the same select codes.
- One natural sub-module: access_timer. It is a loadable down-counter with a zero flag, async-reset, and is reusable for other multi-cycle units.

Test Plan:
Use MEM_LATENCY=2, DATA_MAX_STREAK=3 unless stated.
- Reset: rst=1 mid-run → all outputs 0 within the same cycle; after release with no req, stay IDLE with mem_en=0.
- Lone fetch: if_req=1 at cycle 0 → mem_en=1, mem_sel=0 at cycles 1–2; if_ready=1 only at cycle 2; mem_en=0 at cycle 3.
- Collision: if_req=d_req=1, d_we=0 at cycle 0 → data served cycles 1–2 (mem_sel=1, d_ready at 2); fetch granted at 3, served 4–5, if_ready at 5.
- Store: d_req=1, d_we=1 → mem_we=1 exactly on both ACCESS cycles; d_we toggled at cycle 2 has no effect.
- Starvation: if_req and d_req held high continuously → three data grants, then the 4th grant is fetch (mem_sel=0); streak returns to 0.
- Reset mid-access: rst pulsed at cycle 1 of a data access → no d_ready. After release with d_req still high, re-grant occurs and d_ready arrives MEM_LATENCY cycles after the first IDLE edge.
- Latency sweep: MEM_LATENCY=1 → ready on the cycle right after grant; throughput one access per 2 cycles.
